// File: rtl/reg_file_2w2r.sv
// -----------------------------------------------------------------------------
// reg_file_2w2r
// Register file for the decode stage: two combinational read ports, two
// synchronous write ports (port 1 = ALU writeback, port 2 = load/NoC
// writeback) and a per-register busy scoreboard. The pipeline uses the
// scoreboard to stall on results that are still in flight.
//
// Parameters:
//   DATA_WIDTH  register width in bits
//   ADDR_WIDTH  address width; the file holds 2**ADDR_WIDTH registers
//
// Ports:
//   CLK                   clock; all state updates on the rising edge
//   RESET                 synchronous active-high clear of data and busy bits
//   IN1/INADDRESS1/WRITE_EN1  write port 1
//   IN2/INADDRESS2/WRITE_EN2  write port 2 (wins on an address collision)
//   OUT1ADDRESS/OUT1/OUT1BUSY read port 1 (data + busy bit)
//   OUT2ADDRESS/OUT2/OUT2BUSY read port 2 (data + busy bit)
//   MARK_EN/MARK_ADDRESS  sets the busy bit of an issued destination
//
// Register 0 is hardwired to zero and never busy.
//
// Optional build macro REG_FILE_BYPASS_EN: when defined, reads forward the
// data being written in the same cycle (port 2 over port 1). The busy bit
// of a forwarded address reads 0 unless a mark targets it in the same cycle.
// When undefined, reads show committed state only.
// -----------------------------------------------------------------------------
module reg_file_2w2r #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN1,
    input  logic [ADDR_WIDTH-1:0] INADDRESS1,
    input  logic                  WRITE_EN1,
    input  logic [DATA_WIDTH-1:0] IN2,
    input  logic [ADDR_WIDTH-1:0] INADDRESS2,
    input  logic                  WRITE_EN2,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    input  logic                  MARK_EN,
    input  logic [ADDR_WIDTH-1:0] MARK_ADDRESS,
    output logic                  OUT1BUSY,
    output logic                  OUT2BUSY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    logic                  wr1_ok_s;
    logic                  wr2_ok_s;
    logic                  mark_ok_s;

    logic [ADDR_WIDTH-1:0] rd_addr_s [2];
    logic [DATA_WIDTH-1:0] rd_data_s [2];
    logic [1:0]            rd_busy_s;

    // Qualify write and mark requests: anything aimed at register 0 is dropped.
    always_comb begin
        wr1_ok_s  = WRITE_EN1 && (INADDRESS1 != ZERO_ADDR);
        wr2_ok_s  = WRITE_EN2 && (INADDRESS2 != ZERO_ADDR);
        mark_ok_s = MARK_EN && (MARK_ADDRESS != ZERO_ADDR);
    end

    // Next-state for data and busy bits: port 2 beats port 1 on data; a mark
    // beats a write on busy because the newly issued producer supersedes the
    // one retiring now. A discarded port-1 write still clears busy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr2_ok_s && (INADDRESS2 == ADDR_WIDTH'(i))) begin
                regs_d[i] = IN2;
            end else if (wr1_ok_s && (INADDRESS1 == ADDR_WIDTH'(i))) begin
                regs_d[i] = IN1;
            end else begin
                regs_d[i] = regs_q[i];
            end

            if (mark_ok_s && (MARK_ADDRESS == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((wr1_ok_s && (INADDRESS1 == ADDR_WIDTH'(i))) ||
                         (wr2_ok_s && (INADDRESS2 == ADDR_WIDTH'(i)))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // State registers; RESET overrides every write and mark in its cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= ZERO_DATA;
            end
            busy_q <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Gather the two read addresses so both ports share one read path.
    always_comb begin
        rd_addr_s[0] = OUT1ADDRESS;
        rd_addr_s[1] = OUT2ADDRESS;
    end

    // Combinational read ports, optionally forwarding same-cycle writes.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rd_data_s[k] = ZERO_DATA;
            rd_busy_s[k] = 1'b0;
            if (rd_addr_s[k] == ZERO_ADDR) begin
                rd_data_s[k] = ZERO_DATA;
                rd_busy_s[k] = 1'b0;
`ifdef REG_FILE_BYPASS_EN
            end else if (wr2_ok_s && (INADDRESS2 == rd_addr_s[k])) begin
                rd_data_s[k] = IN2;
                rd_busy_s[k] = mark_ok_s && (MARK_ADDRESS == rd_addr_s[k]);
            end else if (wr1_ok_s && (INADDRESS1 == rd_addr_s[k])) begin
                rd_data_s[k] = IN1;
                rd_busy_s[k] = mark_ok_s && (MARK_ADDRESS == rd_addr_s[k]);
`endif
            end else begin
                rd_data_s[k] = regs_q[rd_addr_s[k]];
                rd_busy_s[k] = busy_q[rd_addr_s[k]];
            end
        end
    end

    assign OUT1     = rd_data_s[0];
    assign OUT2     = rd_data_s[1];
    assign OUT1BUSY = rd_busy_s[0];
    assign OUT2BUSY = rd_busy_s[1];

endmodule

// File: tb/tb_reg_file_2w2r.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2w2r
// Self-checking bench for reg_file_2w2r (default 32-bit data, 32 registers).
// Directed vectors with hand-computed expectations cover reset, register 0,
// dual and colliding writes, the busy scoreboard and read forwarding, then a
// short randomised run is checked against a small reference model.
// Expectations that depend on REG_FILE_BYPASS_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_reg_file_2w2r;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic [31:0] in1_s, in2_s;
    logic [4:0]  ia1_s, ia2_s;
    logic        we1_s, we2_s;
    logic [4:0]  ra1_s, ra2_s;
    logic [31:0] out1_s, out2_s;
    logic        mark_en_s;
    logic [4:0]  mark_addr_s;
    logic        busy1_s, busy2_s;

    int checks_r = 0;
    int errors_r = 0;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    always #5 clk_s = ~clk_s;

    reg_file_2w2r #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(clk_s), .RESET(rst_s),
        .IN1(in1_s), .INADDRESS1(ia1_s), .WRITE_EN1(we1_s),
        .IN2(in2_s), .INADDRESS2(ia2_s), .WRITE_EN2(we2_s),
        .OUT1ADDRESS(ra1_s), .OUT2ADDRESS(ra2_s),
        .OUT1(out1_s), .OUT2(out2_s),
        .MARK_EN(mark_en_s), .MARK_ADDRESS(mark_addr_s),
        .OUT1BUSY(busy1_s), .OUT2BUSY(busy2_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic idle();
        rst_s = 1'b0; we1_s = 1'b0; we2_s = 1'b0; mark_en_s = 1'b0;
    endtask

    // Expected read data / busy for the random phase, from the model.
    function automatic logic [31:0] exp_data(input logic [4:0] ra);
        logic [31:0] v;
        v = (ra == 5'd0) ? 32'd0 : m_reg[ra];
        if (BYP && ra != 5'd0) begin
            if (we2_s && ia2_s == ra) v = in2_s;
            else if (we1_s && ia1_s == ra) v = in1_s;
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        logic b;
        b = (ra == 5'd0) ? 1'b0 : m_busy[ra];
        if (BYP && ra != 5'd0 && ((we2_s && ia2_s == ra) || (we1_s && ia1_s == ra)))
            b = mark_en_s && (mark_addr_s == ra);
        return b;
    endfunction

    initial begin
        idle();
        rst_s = 1'b1;
        in1_s = 32'd0; in2_s = 32'd0; ia1_s = 5'd0; ia2_s = 5'd0;
        ra1_s = 5'd0; ra2_s = 5'd0; mark_addr_s = 5'd0;
        tick();
        idle();

        // ---- reset ----
        ra1_s = 5'd5; ra2_s = 5'd5; #1;
        check_val("rst_init_out1", out1_s, 32'd0);
        check_val("rst_init_busy1", 32'(busy1_s), 32'd0);
        we1_s = 1'b1; ia1_s = 5'd5; in1_s = 32'hDEADBEEF; mark_en_s = 1'b1; mark_addr_s = 5'd5;
        tick(); idle(); #1;
        check_val("wr_r5", out1_s, 32'hDEADBEEF);
        check_val("mark_r5", 32'(busy1_s), 32'd1);
        rst_s = 1'b1; tick(); idle(); #1;
        check_val("rst_r5_out1", out1_s, 32'd0);
        check_val("rst_r5_busy1", 32'(busy1_s), 32'd0);
        rst_s = 1'b1; we1_s = 1'b1; ia1_s = 5'd5; in1_s = 32'h1234; mark_en_s = 1'b1;
        tick(); idle(); #1;
        check_val("rst_over_wr", out1_s, 32'd0);
        check_val("rst_over_mark", 32'(busy1_s), 32'd0);

        // ---- register 0 ----
        we1_s = 1'b1; ia1_s = 5'd0; in1_s = 32'h2;
        we2_s = 1'b1; ia2_s = 5'd0; in2_s = 32'h2;
        mark_en_s = 1'b1; mark_addr_s = 5'd0;
        ra1_s = 5'd0; ra2_s = 5'd0;
        tick(); idle(); #1;
        check_val("r0_out1", out1_s, 32'd0);
        check_val("r0_out2", out2_s, 32'd0);
        check_val("r0_busy1", 32'(busy1_s), 32'd0);
        check_val("r0_busy2", 32'(busy2_s), 32'd0);

        // ---- dual write ----
        we1_s = 1'b1; ia1_s = 5'd3; in1_s = 32'h11;
        we2_s = 1'b1; ia2_s = 5'd7; in2_s = 32'h22;
        tick(); idle(); ra1_s = 5'd3; ra2_s = 5'd7; #1;
        check_val("dual_r3", out1_s, 32'h11);
        check_val("dual_r7", out2_s, 32'h22);
        we1_s = 1'b1; ia1_s = 5'd4; in1_s = 32'hAA;
        we2_s = 1'b1; ia2_s = 5'd4; in2_s = 32'hBB;
        tick(); idle(); ra1_s = 5'd4; ra2_s = 5'd3; #1;
        check_val("collide_r4", out1_s, 32'hBB);
        check_val("collide_r3_kept", out2_s, 32'h11);

        // ---- scoreboard ----
        mark_en_s = 1'b1; mark_addr_s = 5'd9; ra2_s = 5'd9;
        tick(); idle(); #1;
        check_val("mark_r9", 32'(busy2_s), 32'd1);
        mark_en_s = 1'b1; mark_addr_s = 5'd9;
        tick(); idle(); #1;
        check_val("remark_r9", 32'(busy2_s), 32'd1);
        we1_s = 1'b1; ia1_s = 5'd9; in1_s = 32'h5;
        tick(); idle(); #1;
        check_val("wr_clr_busy_r9", 32'(busy2_s), 32'd0);
        check_val("wr_data_r9", out2_s, 32'h5);
        we1_s = 1'b1; ia1_s = 5'd9; in1_s = 32'h6; mark_en_s = 1'b1; mark_addr_s = 5'd9;
        tick(); idle(); #1;
        check_val("mark_wins_busy", 32'(busy2_s), 32'd1);
        check_val("mark_wins_data", out2_s, 32'h6);
        mark_en_s = 1'b1; mark_addr_s = 5'd10;
        tick(); idle();
        we1_s = 1'b1; ia1_s = 5'd10; in1_s = 32'h1;
        we2_s = 1'b1; ia2_s = 5'd10; in2_s = 32'h2;
        tick(); idle(); ra2_s = 5'd10; #1;
        check_val("collide_clr_busy", 32'(busy2_s), 32'd0);
        check_val("collide_r10", out2_s, 32'h2);

        // ---- forwarding ----
        we1_s = 1'b1; ia1_s = 5'd12; in1_s = 32'h33; mark_en_s = 1'b1; mark_addr_s = 5'd12;
        tick(); idle(); ra1_s = 5'd12; #1;
        check_val("r12_base", out1_s, 32'h33);
        check_val("r12_base_busy", 32'(busy1_s), 32'd1);
        we2_s = 1'b1; ia2_s = 5'd12; in2_s = 32'h77; #1;
        check_val("byp_p2_data", out1_s, BYP ? 32'h77 : 32'h33);
        check_val("byp_p2_busy", 32'(busy1_s), BYP ? 32'd0 : 32'd1);
        tick(); idle(); #1;
        check_val("after_p2_data", out1_s, 32'h77);
        check_val("after_p2_busy", 32'(busy1_s), 32'd0);
        we1_s = 1'b1; ia1_s = 5'd12; in1_s = 32'h88;
        we2_s = 1'b1; ia2_s = 5'd12; in2_s = 32'h99; #1;
        check_val("byp_prio", out1_s, BYP ? 32'h99 : 32'h77);
        tick(); idle(); #1;
        check_val("after_prio", out1_s, 32'h99);
        we1_s = 1'b1; ia1_s = 5'd12; in1_s = 32'h55; mark_en_s = 1'b1; mark_addr_s = 5'd12; #1;
        check_val("byp_p1_data", out1_s, BYP ? 32'h55 : 32'h99);
        check_val("byp_p1_mark", 32'(busy1_s), BYP ? 32'd1 : 32'd0);
        tick(); idle(); #1;
        check_val("after_p1_data", out1_s, 32'h55);
        check_val("after_p1_busy", 32'(busy1_s), 32'd1);

        // ---- randomised run against the model ----
        rst_s = 1'b1; tick(); idle();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
        for (int c = 0; c < 1000; c++) begin
            rst_s       = ($urandom_range(0, 63) == 0);
            we1_s       = 1'($urandom_range(0, 1));
            we2_s       = 1'($urandom_range(0, 1));
            mark_en_s   = 1'($urandom_range(0, 1));
            ia1_s       = 5'($urandom_range(0, 7));
            ia2_s       = 5'($urandom_range(0, 7));
            mark_addr_s = 5'($urandom_range(0, 7));
            ra1_s       = 5'($urandom_range(0, 7));
            ra2_s       = 5'($urandom_range(0, 31));
            in1_s       = $urandom();
            in2_s       = $urandom();
            #1;
            if (!rst_s) begin
                check_val("rnd_out1", out1_s, exp_data(ra1_s));
                check_val("rnd_out2", out2_s, exp_data(ra2_s));
                check_val("rnd_busy1", 32'(busy1_s), 32'(exp_busy(ra1_s)));
                check_val("rnd_busy2", 32'(busy2_s), 32'(exp_busy(ra2_s)));
            end
            tick();
            if (rst_s) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[i] = 32'd0;
                    m_busy[i] = 1'b0;
                end
            end else begin
                if (we1_s && ia1_s != 5'd0) begin
                    m_reg[ia1_s] = in1_s;
                    m_busy[ia1_s] = 1'b0;
                end
                if (we2_s && ia2_s != 5'd0) begin
                    m_reg[ia2_s] = in2_s;
                    m_busy[ia2_s] = 1'b0;
                end
                if (mark_en_s && mark_addr_s != 5'd0) m_busy[mark_addr_s] = 1'b1;
            end
        end

        // Full sweep of committed state after the random run.
        idle();
        for (int a = 0; a < 32; a++) begin
            ra1_s = 5'(a); ra2_s = 5'(a); #1;
            check_val("sweep_data", out1_s, (a == 0) ? 32'd0 : m_reg[a]);
            check_val("sweep_busy", 32'(busy2_s), (a == 0) ? 32'd0 : 32'(m_busy[a]));
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
